axi_slave_mem_resp: RTL and testbench

AXI_SLAVE_MEM_RESP -- requirements
Module: axi_slave_mem_resp

---
 rtl/axi_slave_mem_resp.sv | 273 +++++++++++++++++++++++++++
 tb/tb_axi_slave_mem_resp.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem_resp.sv
// AXI4 slave backed by a byte-strobed word array; optional range check via AXI_SLAVE_MEM_RANGE_CHECK_EN.
// Latency: read data 1 cycle after AR handshake, combinational from the array; B issued after the last W beat.
// Backpressure: independent read/write FSMs; R and B outputs hold while valid is high and ready is low.
module axi_slave_mem_resp #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6,
    parameter int MEM_WORDS      = 256
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,

    input  logic                        axi_slave_aw_valid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr,
    input  logic [2:0]                  axi_slave_aw_prot,
    input  logic [3:0]                  axi_slave_aw_region,
    input  logic [7:0]                  axi_slave_aw_len,
    input  logic [2:0]                  axi_slave_aw_size,
    input  logic [1:0]                  axi_slave_aw_burst,
    input  logic                        axi_slave_aw_lock,
    input  logic [3:0]                  axi_slave_aw_cache,
    input  logic [3:0]                  axi_slave_aw_qos,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_aw_user,
    output logic                        axi_slave_aw_ready,

    input  logic                        axi_slave_w_valid,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb,
    input  logic                        axi_slave_w_last,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_w_user,
    output logic                        axi_slave_w_ready,

    output logic                        axi_slave_b_valid,
    output logic [1:0]                  axi_slave_b_resp,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id,
    output logic [AXI_USER_WIDTH-1:0]   axi_slave_b_user,
    input  logic                        axi_slave_b_ready,

    input  logic                        axi_slave_ar_valid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr,
    input  logic [2:0]                  axi_slave_ar_prot,
    input  logic [3:0]                  axi_slave_ar_region,
    input  logic [7:0]                  axi_slave_ar_len,
    input  logic [2:0]                  axi_slave_ar_size,
    input  logic [1:0]                  axi_slave_ar_burst,
    input  logic                        axi_slave_ar_lock,
    input  logic [3:0]                  axi_slave_ar_cache,
    input  logic [3:0]                  axi_slave_ar_qos,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_ar_user,
    output logic                        axi_slave_ar_ready,

    output logic                        axi_slave_r_valid,
    output logic [AXI_DATA_WIDTH-1:0]   axi_slave_r_data,
    output logic [1:0]                  axi_slave_r_resp,
    output logic                        axi_slave_r_last,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_r_id,
    output logic [AXI_USER_WIDTH-1:0]   axi_slave_r_user,
    input  logic                        axi_slave_r_ready
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    w_state_e                  w_state_q, w_state_d;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_q,  w_addr_d;
    logic [7:0]                w_len_q,   w_len_d;
    logic [2:0]                w_size_q,  w_size_d;
    logic [1:0]                w_burst_q, w_burst_d;
    logic [AXI_ID_WIDTH-1:0]   w_id_q,    w_id_d;
    logic [7:0]                w_cnt_q,   w_cnt_d;
    logic                      w_err_q,   w_err_d;

    r_state_e                  r_state_q, r_state_d;
    logic [AXI_ADDR_WIDTH-1:0] r_addr_q,  r_addr_d;
    logic [7:0]                r_len_q,   r_len_d;
    logic [2:0]                r_size_q,  r_size_d;
    logic [1:0]                r_burst_q, r_burst_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q,    r_id_d;
    logic [7:0]                r_cnt_q,   r_cnt_d;

    logic             mem_we;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             w_beat_last;

    // FIXED holds the address; INCR and WRAP both step by the beat size.
    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] addr,
        input logic [2:0]                size,
        input logic [1:0]                burst
    );
        if (burst == 2'b00) begin
            return addr;
        end
        return addr + (AXI_ADDR_WIDTH'(1) << size);
    endfunction

    assign wr_idx      = w_addr_q[IDX_W+2:3];
    assign rd_idx      = r_addr_q[IDX_W+2:3];
    assign w_beat_last = (w_cnt_q == w_len_q);

`ifdef AXI_SLAVE_MEM_RANGE_CHECK_EN
    assign wr_in_range = (w_addr_q < AXI_ADDR_WIDTH'(MEM_WORDS * 8));
    assign rd_in_range = (r_addr_q < AXI_ADDR_WIDTH'(MEM_WORDS * 8));
`else
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
`endif

    // Write channel next state and outputs.
    always_comb begin
        w_state_d          = w_state_q;
        w_addr_d           = w_addr_q;
        w_len_d            = w_len_q;
        w_size_d           = w_size_q;
        w_burst_d          = w_burst_q;
        w_id_d             = w_id_q;
        w_cnt_d            = w_cnt_q;
        w_err_d            = w_err_q;
        axi_slave_aw_ready = 1'b0;
        axi_slave_w_ready  = 1'b0;
        axi_slave_b_valid  = 1'b0;
        mem_we             = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                axi_slave_aw_ready = 1'b1;
                if (axi_slave_aw_valid) begin
                    w_addr_d  = axi_slave_aw_addr;
                    w_len_d   = axi_slave_aw_len;
                    w_size_d  = axi_slave_aw_size;
                    w_burst_d = axi_slave_aw_burst;
                    w_id_d    = axi_slave_aw_id;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                axi_slave_w_ready = 1'b1;
                if (axi_slave_w_valid) begin
                    mem_we   = wr_in_range;
                    w_err_d  = w_err_q | ~wr_in_range | (axi_slave_w_last != w_beat_last);
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_beat_last || axi_slave_w_last) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                axi_slave_b_valid = 1'b1;
                if (axi_slave_b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign axi_slave_b_resp = w_err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_slave_b_id   = w_id_q;
    assign axi_slave_b_user = '0;

    // Read channel next state and outputs.
    always_comb begin
        r_state_d          = r_state_q;
        r_addr_d           = r_addr_q;
        r_len_d            = r_len_q;
        r_size_d           = r_size_q;
        r_burst_d          = r_burst_q;
        r_id_d             = r_id_q;
        r_cnt_d            = r_cnt_q;
        axi_slave_ar_ready = 1'b0;
        axi_slave_r_valid  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                axi_slave_ar_ready = 1'b1;
                if (axi_slave_ar_valid) begin
                    r_addr_d  = axi_slave_ar_addr;
                    r_len_d   = axi_slave_ar_len;
                    r_size_d  = axi_slave_ar_size;
                    r_burst_d = axi_slave_ar_burst;
                    r_id_d    = axi_slave_ar_id;
                    r_cnt_d   = 8'd0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                axi_slave_r_valid = 1'b1;
                if (axi_slave_r_ready) begin
                    r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q);
                    r_cnt_d  = r_cnt_q + 8'd1;
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Array read is combinational, so a same-edge write is seen only from the next cycle.
    assign axi_slave_r_data = rd_in_range ? mem_q[rd_idx] : '0;
    assign axi_slave_r_resp = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    assign axi_slave_r_last = (r_cnt_q == r_len_q);
    assign axi_slave_r_id   = r_id_q;
    assign axi_slave_r_user = '0;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_id_q    <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_id_q    <= '0;
            r_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_id_q    <= w_id_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_id_q    <= r_id_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge axi_aclk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (mem_we && axi_slave_w_strb[i]) begin
                mem_q[wr_idx][8*i +: 8] <= axi_slave_w_data[8*i +: 8];
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{axi_slave_aw_prot, axi_slave_aw_region, axi_slave_aw_lock,
                             axi_slave_aw_cache, axi_slave_aw_qos, axi_slave_aw_user,
                             axi_slave_w_user,
                             axi_slave_ar_prot, axi_slave_ar_region, axi_slave_ar_lock,
                             axi_slave_ar_cache, axi_slave_ar_qos, axi_slave_ar_user};

endmodule

// File: tb/tb_axi_slave_mem_resp.sv
// Bench for axi_slave_mem_resp: directed and random bursts checked against a word-array model.
module tb_axi_slave_mem_resp;

`ifdef AXI_SLAVE_MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        aw_valid = 0, aw_ready;
    logic [31:0] aw_addr = 0;
    logic [7:0]  aw_len = 0;
    logic [2:0]  aw_size = 0;
    logic [1:0]  aw_burst = 0;
    logic [2:0]  aw_id = 0;
    logic        w_valid = 0, w_ready, w_last = 0;
    logic [63:0] w_data = 0;
    logic [7:0]  w_strb = 0;
    logic        b_valid, b_ready = 0;
    logic [1:0]  b_resp;
    logic [2:0]  b_id;
    logic [5:0]  b_user;
    logic        ar_valid = 0, ar_ready;
    logic [31:0] ar_addr = 0;
    logic [7:0]  ar_len = 0;
    logic [2:0]  ar_size = 0;
    logic [1:0]  ar_burst = 0;
    logic [2:0]  ar_id = 0;
    logic        r_valid, r_ready = 0, r_last;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [2:0]  r_id;
    logic [5:0]  r_user;

    axi_slave_mem_resp dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .axi_slave_aw_valid(aw_valid), .axi_slave_aw_addr(aw_addr), .axi_slave_aw_prot(3'd5),
        .axi_slave_aw_region(4'd3), .axi_slave_aw_len(aw_len), .axi_slave_aw_size(aw_size),
        .axi_slave_aw_burst(aw_burst), .axi_slave_aw_lock(1'b1), .axi_slave_aw_cache(4'hA),
        .axi_slave_aw_qos(4'h5), .axi_slave_aw_id(aw_id), .axi_slave_aw_user(6'h2A),
        .axi_slave_aw_ready(aw_ready),
        .axi_slave_w_valid(w_valid), .axi_slave_w_data(w_data), .axi_slave_w_strb(w_strb),
        .axi_slave_w_last(w_last), .axi_slave_w_user(6'h15), .axi_slave_w_ready(w_ready),
        .axi_slave_b_valid(b_valid), .axi_slave_b_resp(b_resp), .axi_slave_b_id(b_id),
        .axi_slave_b_user(b_user), .axi_slave_b_ready(b_ready),
        .axi_slave_ar_valid(ar_valid), .axi_slave_ar_addr(ar_addr), .axi_slave_ar_prot(3'd2),
        .axi_slave_ar_region(4'd9), .axi_slave_ar_len(ar_len), .axi_slave_ar_size(ar_size),
        .axi_slave_ar_burst(ar_burst), .axi_slave_ar_lock(1'b1), .axi_slave_ar_cache(4'h3),
        .axi_slave_ar_qos(4'hC), .axi_slave_ar_id(ar_id), .axi_slave_ar_user(6'h3F),
        .axi_slave_ar_ready(ar_ready),
        .axi_slave_r_valid(r_valid), .axi_slave_r_data(r_data), .axi_slave_r_resp(r_resp),
        .axi_slave_r_last(r_last), .axi_slave_r_id(r_id), .axi_slave_r_user(r_user),
        .axi_slave_r_ready(r_ready)
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] model [256];
    logic [63:0] wdat  [256];
    logic [7:0]  wstrb [256];

    // Beat address in closed form: FIXED repeats, INCR/WRAP step by 2^size.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst, input int b);
        if (burst == 2'b00) return a;
        return a + 32'(b) * (32'd1 << size);
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst,
                                               input int last_at);
        logic err;
        logic [31:0] ba;
        err = (last_at != int'(len));
        for (int b = 0; b <= last_at; b++) begin
            ba = beat_addr(a, size, burst, b);
            if (RC && ba >= 32'h800) begin
                err = 1'b1;
            end else begin
                for (int k = 0; k < 8; k++)
                    if (wstrb[b][k]) model[ba[10:3]][8*k +: 8] = wdat[b][8*k +: 8];
            end
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic timeout(input string what);
        checks++; errors++;
        $display("FAIL timeout %s", what);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [2:0] id, input int last_at,
                             output logic [1:0] resp, output logic [2:0] rid, output int nresp);
        int t;
        resp = 2'bxx; rid = 3'bxxx; nresp = 0;
        @(negedge clk);
        aw_valid = 1; aw_addr = a; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id;
        t = 0;
        while (!aw_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout("aw_ready");
        @(negedge clk);
        aw_valid = 0;
        for (int b = 0; b <= last_at; b++) begin
            w_valid = 1; w_data = wdat[b]; w_strb = wstrb[b]; w_last = (b == last_at);
            t = 0;
            while (!w_ready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) timeout("w_ready");
            @(negedge clk);
        end
        w_valid = 0; w_last = 0;
        t = 0;
        while (!b_valid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            timeout("b_valid");
        end else begin
            resp = b_resp; rid = b_id; nresp = 1;
            checks++;
            if (b_user !== 6'd0) begin errors++; $display("FAIL b_user got %h want 0", b_user); end
            b_ready = 1;
            @(negedge clk);
            b_ready = 0;
            repeat (3) begin
                if (b_valid) nresp++;
                @(negedge clk);
            end
        end
    endtask

    task automatic write_check(input string name, input logic [31:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [2:0] id, input int last_at);
        logic [1:0] resp, exp;
        logic [2:0] rid;
        int nresp;
        exp = model_write(a, len, size, burst, last_at);
        axi_write(a, len, size, burst, id, last_at, resp, rid, nresp);
        checks++;
        if (resp !== exp || rid !== id || nresp != 1) begin
            errors++;
            $display("FAIL %s B resp=%b id=%0d count=%0d want resp=%b id=%0d count=1",
                     name, resp, rid, nresp, exp, id);
        end
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [2:0] id, input bit toggle);
        int t;
        logic [31:0] ba;
        logic [63:0] ed, held;
        logic [1:0]  er;
        @(negedge clk);
        ar_valid = 1; ar_addr = a; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id;
        t = 0;
        while (!ar_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout("ar_ready");
        @(negedge clk);
        ar_valid = 0;
        checks++;
        if (r_valid !== 1'b1) begin errors++; $display("FAIL %s latency r_valid=%b want 1", name, r_valid); end
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!r_valid && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) begin timeout("r_valid"); return; end
            ba = beat_addr(a, size, burst, b);
            if (RC && ba >= 32'h800) begin ed = 64'd0; er = 2'b10; end
            else begin ed = model[ba[10:3]]; er = 2'b00; end
            if (toggle) begin
                held = r_data;
                @(negedge clk);
                checks++;
                if (r_valid !== 1'b1 || r_data !== held) begin
                    errors++;
                    $display("FAIL %s hold beat %0d valid=%b data=%h want 1 %h", name, b, r_valid, r_data, held);
                end
            end
            checks++;
            if (r_data !== ed || r_resp !== er || r_last !== (b == int'(len)) || r_id !== id || r_user !== 6'd0) begin
                errors++;
                $display("FAIL %s beat %0d data=%h resp=%b last=%b id=%0d user=%0d want %h %b %b %0d 0",
                         name, b, r_data, r_resp, r_last, r_id, r_user, ed, er, (b == int'(len)), id);
            end
            r_ready = 1;
            @(negedge clk);
            r_ready = 0;
        end
        checks++;
        if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s end r_valid=%b ar_ready=%b want 0 1", name, r_valid, ar_ready);
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (aw_ready !== 1 || ar_ready !== 1 || b_valid !== 0 || r_valid !== 0 || w_ready !== 0) begin
            errors++;
            $display("FAIL reset aw_rdy=%b ar_rdy=%b b_vld=%b r_vld=%b w_rdy=%b want 1 1 0 0 0",
                     aw_ready, ar_ready, b_valid, r_valid, w_ready);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 256; i++) begin wdat[i] = {$urandom, $urandom}; wstrb[i] = 8'hFF; end
        write_check("fill", 32'h0, 8'd255, 3'd3, 2'b01, 3'd1, 255);
    endtask

    task automatic test_single;
        wdat[0] = 64'h1122334455667788; wstrb[0] = 8'hFF;
        write_check("single_w", 32'h10, 8'd0, 3'd3, 2'b01, 3'd6, 0);
        read_check("single_r", 32'h10, 8'd0, 3'd3, 2'b01, 3'd2, 1'b0);
    endtask

    task automatic test_strobe;
        wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb[0] = 8'hFF;
        write_check("strb_ones", 32'h0, 8'd0, 3'd3, 2'b01, 3'd3, 0);
        wdat[0] = 64'h0; wstrb[0] = 8'h0F;
        write_check("strb_low", 32'h0, 8'd0, 3'd3, 2'b01, 3'd3, 0);
        read_check("strb_r", 32'h0, 8'd0, 3'd3, 2'b01, 3'd4, 1'b0);
    endtask

    task automatic test_incr_burst;
        for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); wstrb[i] = 8'hFF; end
        write_check("incr_w", 32'h20, 8'd3, 3'd3, 2'b01, 3'd7, 3);
        read_check("incr_r", 32'h20, 8'd3, 3'd3, 2'b01, 3'd7, 1'b1);
    endtask

    task automatic test_wlast_early;
        for (int i = 0; i < 4; i++) begin wdat[i] = {$urandom, $urandom}; wstrb[i] = 8'hFF; end
        write_check("wlast_early", 32'h80, 8'd3, 3'd3, 2'b01, 3'd2, 1);
        checks++;
        if (aw_ready !== 1'b1 || w_ready !== 1'b0) begin
            errors++;
            $display("FAIL wlast_idle aw_ready=%b w_ready=%b want 1 0", aw_ready, w_ready);
        end
        read_check("wlast_r", 32'h80, 8'd3, 3'd3, 2'b01, 3'd0, 1'b0);
    endtask

    task automatic test_fixed;
        for (int i = 0; i < 3; i++) begin wdat[i] = {$urandom, $urandom}; wstrb[i] = 8'($urandom); end
        write_check("fixed_w", 32'h100, 8'd2, 3'd3, 2'b00, 3'd5, 2);
        read_check("fixed_r", 32'h100, 8'd2, 3'd3, 2'b00, 3'd5, 1'b1);
    endtask

    task automatic test_range;
        wdat[0] = {$urandom, $urandom}; wstrb[0] = 8'hFF;
        write_check("range_w", 32'h800, 8'd0, 3'd3, 2'b01, 3'd1, 0);
        read_check("range_r", 32'h800, 8'd0, 3'd3, 2'b01, 3'd1, 1'b0);
        read_check("range_span", 32'h7F8, 8'd1, 3'd3, 2'b01, 3'd2, 1'b0);
    endtask

    task automatic test_collision;
        logic [63:0] old_w, new_w;
        old_w = model[8]; new_w = ~old_w ^ {$urandom, $urandom};
        @(negedge clk);
        aw_valid = 1; aw_addr = 32'h40; aw_len = 0; aw_size = 3; aw_burst = 2'b01; aw_id = 3'd5;
        ar_valid = 1; ar_addr = 32'h40; ar_len = 1; ar_size = 3; ar_burst = 2'b00; ar_id = 3'd6;
        checks++;
        if (aw_ready !== 1 || ar_ready !== 1) begin
            errors++; $display("FAIL coll_ready aw=%b ar=%b want 1 1", aw_ready, ar_ready);
        end
        @(negedge clk);
        aw_valid = 0; ar_valid = 0;
        w_valid = 1; w_data = new_w; w_strb = 8'hFF; w_last = 1; r_ready = 1;
        checks++;
        if (r_valid !== 1 || r_data !== old_w || r_last !== 0) begin
            errors++; $display("FAIL coll_old data=%h last=%b want %h 0", r_data, r_last, old_w);
        end
        @(negedge clk);
        w_valid = 0; w_last = 0;
        checks++;
        if (r_valid !== 1 || r_data !== new_w || r_last !== 1 || b_valid !== 1 || b_id !== 3'd5) begin
            errors++; $display("FAIL coll_new data=%h last=%b b_vld=%b want %h 1 1", r_data, r_last, b_valid, new_w);
        end
        @(negedge clk);
        r_ready = 0; b_ready = 1;
        @(negedge clk);
        b_ready = 0;
        model[8] = new_w;
        checks++;
        if (r_valid !== 0 || b_valid !== 0) begin
            errors++; $display("FAIL coll_done r_vld=%b b_vld=%b want 0 0", r_valid, b_valid);
        end
    endtask

    task automatic test_reset_mid_burst;
        int stale;
        @(negedge clk);
        ar_valid = 1; ar_addr = 32'h20; ar_len = 3; ar_size = 3; ar_burst = 2'b01; ar_id = 3'd3;
        @(negedge clk);
        ar_valid = 0; r_ready = 1;
        @(negedge clk);
        r_ready = 0;
        rst_n = 0;
        #1;
        checks++;
        if (r_valid !== 0 || ar_ready !== 1) begin
            errors++; $display("FAIL rst_mid r_valid=%b ar_ready=%b want 0 1", r_valid, ar_ready);
        end
        @(negedge clk);
        rst_n = 1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (r_valid || b_valid || !ar_ready || !aw_ready) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL rst_stale cycles=%0d want 0", stale); end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  size, id;
        logic [1:0]  burst;
        int last_at;
        for (int n = 0; n < 12; n++) begin
            a = 32'($urandom_range(0, 32'h6FF));
            len = 8'($urandom_range(0, 7));
            size = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 2));
            id = 3'($urandom);
            last_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(len)) : int'(len);
            for (int i = 0; i < 8; i++) begin wdat[i] = {$urandom, $urandom}; wstrb[i] = 8'($urandom); end
            write_check("rand_w", a, len, size, burst, id, last_at);
            read_check("rand_r", a, len, size, burst, 3'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_single;
        test_strobe;
        test_incr_burst;
        test_wlast_early;
        test_fixed;
        test_range;
        test_collision;
        test_reset_mid_burst;
        test_random;
        read_check("post_rand", 32'h20, 8'd3, 3'd3, 2'b01, 3'd1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
